ram2_port_arbiter: RTL and testbench

- Shares one two-read/one-write RAM (RAM2: raddr0/rdata0, raddr1/rdata1, waddr/wdata/wen) among NUM_REQ requesters.
- Requesters are HLS-generated kernels or debug/DMA agents. Each presents a single read-or-write request per cycle with a valid/ready handshake.
- Each cycle the arbiter grants up to two reads and one write, in round-robin order.
- It returns read data to the owning requester with fixed latency.

---
 rtl/ram2_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ram2_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2_port_arbiter.sv
// Round-robin arbiter that shares one RAM among NUM_REQ requesters. The RAM
// has two read ports and one write port. Each cycle it grants up to two reads
// and one write. It withholds any read that targets the address being written
// in the same cycle. Read data returns to the owning requester one cycle after
// the grant.
module ram2_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0]         raddr0,
  output logic [ADDR_WIDTH-1:0]         raddr1,
  input  logic [DATA_WIDTH-1:0]         rdata0,
  input  logic [DATA_WIDTH-1:0]         rdata1,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wen,
  output logic [15:0]                   conflict_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Flat request buses unpacked per requester for readable indexing.
  logic [ADDR_WIDTH-1:0] addr_a_s  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a_s [NUM_REQ];

  logic [IDX_W-1:0]      rr_ptr_r;
  logic [IDX_W-1:0]      rr_ptr_nxt_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  wen_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [ADDR_WIDTH-1:0] raddr0_s;
  logic [ADDR_WIDTH-1:0] raddr1_s;
  logic                  rd0_vld_s;
  logic                  rd1_vld_s;
  logic [IDX_W-1:0]      rd0_own_s;
  logic [IDX_W-1:0]      rd1_own_s;
  logic [3:0]            conflict_inc_s;   // at most NUM_REQ (<= 8) skips per cycle
  logic [16:0]           conflict_sum_s;
  logic [15:0]           conflict_nxt_s;

  logic                  rd0_vld_r;
  logic                  rd1_vld_r;
  logic [IDX_W-1:0]      rd0_own_r;
  logic [IDX_W-1:0]      rd1_own_r;
  logic [15:0]           conflict_count_r;

  // Requester index at scan position k, starting from base and wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return IDX_W'(s);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a_s[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a_s[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grant selection: the write pass first, then the read pass (with the
  // hazard check against the granted write), then the pointer advance.
  always_comb begin
    logic [IDX_W-1:0] idx;
    int               ports;
    idx            = '0;
    ports          = 0;
    grant_s        = '0;
    wen_s          = 1'b0;
    waddr_s        = '0;
    wdata_s        = '0;
    raddr0_s       = '0;
    raddr1_s       = '0;
    rd0_vld_s      = 1'b0;
    rd1_vld_s      = 1'b0;
    rd0_own_s      = '0;
    rd1_own_s      = '0;
    conflict_inc_s = 4'd0;
    rr_ptr_nxt_s   = rr_ptr_r;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = scan_idx(rr_ptr_r, k);
        if (!wen_s && req_valid[idx] && req_wen[idx]) begin
          wen_s        = 1'b1;
          waddr_s      = addr_a_s[idx];
          wdata_s      = wdata_a_s[idx];
          grant_s[idx] = 1'b1;
        end else begin
          wen_s = wen_s;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = scan_idx(rr_ptr_r, k);
        if (req_valid[idx] && !req_wen[idx] && (ports < 2)) begin
          if (wen_s && (addr_a_s[idx] == waddr_s)) begin
            // A read of the address being written this cycle waits. The next read in scan order may take its port.
            conflict_inc_s = conflict_inc_s + 4'd1;
          end else if (ports == 0) begin
            raddr0_s     = addr_a_s[idx];
            rd0_vld_s    = 1'b1;
            rd0_own_s    = idx;
            grant_s[idx] = 1'b1;
            ports        = 1;
          end else begin
            raddr1_s     = addr_a_s[idx];
            rd1_vld_s    = 1'b1;
            rd1_own_s    = idx;
            grant_s[idx] = 1'b1;
            ports        = 2;
          end
        end else begin
          ports = ports;
        end
      end
      // Later scan positions overwrite earlier ones, so the last granted position wins.
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = scan_idx(rr_ptr_r, k);
        if (grant_s[idx]) begin
          rr_ptr_nxt_s = scan_idx(rr_ptr_r, k + 1);
        end else begin
          rr_ptr_nxt_s = rr_ptr_nxt_s;
        end
      end
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Saturating next value of the read-stall counter.
  always_comb begin
    conflict_sum_s = {1'b0, conflict_count_r} + {13'd0, conflict_inc_s};
    if (conflict_sum_s[16]) begin
      conflict_nxt_s = 16'hFFFF;
    end else begin
      conflict_nxt_s = conflict_sum_s[15:0];
    end
  end

  // Arbiter state: round-robin pointer, per-port read owner pipeline and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r         <= '0;
      rd0_vld_r        <= 1'b0;
      rd1_vld_r        <= 1'b0;
      rd0_own_r        <= '0;
      rd1_own_r        <= '0;
      conflict_count_r <= 16'd0;
    end else begin
      rr_ptr_r         <= rr_ptr_nxt_s;
      rd0_vld_r        <= rd0_vld_s;
      rd1_vld_r        <= rd1_vld_s;
      rd0_own_r        <= rd0_own_s;
      rd1_own_r        <= rd1_own_s;
      conflict_count_r <= conflict_nxt_s;
    end
  end

  // Route registered RAM data to the requester that owned each read port.
  // Responses are suppressed while rst is high, so reads in flight are dropped.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
    logic hit0_s;
    logic hit1_s;
    assign hit0_s = !rst && rd0_vld_r && (rd0_own_r == IDX_W'(g));
    assign hit1_s = !rst && rd1_vld_r && (rd1_own_r == IDX_W'(g));
    assign resp_valid[g] = hit0_s || hit1_s;
    assign resp_data[g*DATA_WIDTH +: DATA_WIDTH] = hit0_s ? rdata0 : (hit1_s ? rdata1 : '0);
  end

  assign req_ready      = grant_s;
  assign raddr0         = raddr0_s;
  assign raddr1         = raddr1_s;
  assign waddr          = waddr_s;
  assign wdata          = wdata_s;
  assign wen            = wen_s;
  assign conflict_count = conflict_count_r;

endmodule

// File: tb/tb_ram2_port_arbiter.sv
// Directed bench for ram2_port_arbiter with a behavioural RAM2 model.
// Inputs are driven 1 time unit after each rising edge. Outputs are checked
// 3 units later, which is well away from the next edge.
module tb_ram2_port_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_wen;
  logic [19:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [127:0] resp_data;
  logic [4:0]   raddr0;
  logic [4:0]   raddr1;
  logic [31:0]  rdata0;
  logic [31:0]  rdata1;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic         wen;
  logic [15:0]  conflict_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32] = '{default: 32'd0};

  ram2_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .waddr(waddr), .wdata(wdata), .wen(wen), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // RAM2 model: registered reads and a write that lands on the edge.
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 4'b0000;
    req_wen   = 4'b0000;
    req_addr  = 20'd0;
    req_wdata = 128'd0;
  endtask

  task automatic put(input int i, input logic w, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_wen[i]   = w;
    req_addr[i*5 +: 5]    = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          fill_r [5] = '{2, 3, 0, 1, 3};
  logic [4:0]  fill_a [5] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd10};
  logic [31:0] fill_d [5] = '{32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hAA};

  initial begin
    logic [3:0] one;
    clk = 1'b0;
    rst = 1'b1;
    idle();
    // Reset for two edges; a pending request must not be granted.
    tick();
    put(0, 1'b1, 5'd2, 32'd34);
    #3;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wen", wen, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    #3;
    chk("idle_ready", req_ready, 4'b0000);
    chk("idle_wen", wen, 1'b0);
    chk("idle_resp_valid", resp_valid, 4'b0000);
    chk("idle_conflict", conflict_count, 16'd0);
    chk("idle_raddr0", raddr0, 5'd0);
    chk("idle_waddr", waddr, 5'd0);
    chk("idle_wdata", wdata, 32'd0);
    tick();

    // Write then read (rr_ptr=0).
    put(0, 1'b1, 5'd2, 32'd34);
    #3;
    chk("wr_ready", req_ready, 4'b0001);
    chk("wr_wen", wen, 1'b1);
    chk("wr_waddr", waddr, 5'd2);
    chk("wr_wdata", wdata, 32'd34);
    tick();
    idle();
    put(1, 1'b0, 5'd2, 32'd0);
    #3;
    chk("rd_ready", req_ready, 4'b0010);
    chk("rd_raddr0", raddr0, 5'd2);
    chk("rd_wen", wen, 1'b0);
    tick();
    idle();
    #3;
    chk("rd_resp_valid", resp_valid, 4'b0010);
    chk("rd_resp_data", resp_data, {32'd0, 32'd0, 32'd34, 32'd0});
    tick();

    // Fill addresses 3..6. rr_ptr goes 2,3,0,1,2 and then 0.
    for (int i = 0; i < 5; i++) begin
      idle();
      put(fill_r[i], 1'b1, fill_a[i], fill_d[i]);
      one = 4'b0001 << fill_r[i];
      #3;
      chk("fill_ready", req_ready, one);
      chk("fill_waddr", waddr, fill_a[i]);
      tick();
    end

    // Contention: four reads with rr_ptr=0.
    idle();
    put(0, 1'b0, 5'd3, 32'd0);
    put(1, 1'b0, 5'd4, 32'd0);
    put(2, 1'b0, 5'd5, 32'd0);
    put(3, 1'b0, 5'd6, 32'd0);
    #3;
    chk("cont1_ready", req_ready, 4'b0011);
    chk("cont1_raddr0", raddr0, 5'd3);
    chk("cont1_raddr1", raddr1, 5'd4);
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    #3;
    chk("cont2_ready", req_ready, 4'b1100);
    chk("cont2_raddr0", raddr0, 5'd5);
    chk("cont2_raddr1", raddr1, 5'd6);
    chk("cont2_resp_valid", resp_valid, 4'b0011);
    chk("cont2_resp_data", resp_data, {32'd0, 32'd0, 32'hA4, 32'hA3});
    tick();
    idle();
    #3;
    chk("cont3_resp_valid", resp_valid, 4'b1100);
    chk("cont3_resp_data", resp_data, {32'hA6, 32'hA5, 32'd0, 32'd0});
    tick();

    // Hazard (rr_ptr=0).
    put(0, 1'b1, 5'd7, 32'd9);
    put(1, 1'b0, 5'd7, 32'd0);
    put(2, 1'b0, 5'd8, 32'd0);
    #3;
    chk("haz_ready", req_ready, 4'b0101);
    chk("haz_waddr", waddr, 5'd7);
    chk("haz_raddr0", raddr0, 5'd8);
    chk("haz_raddr1", raddr1, 5'd0);
    chk("haz_conflict_pre", conflict_count, 16'd0);
    tick();
    idle();
    put(1, 1'b0, 5'd7, 32'd0);
    #3;
    chk("haz2_conflict", conflict_count, 16'd1);
    chk("haz2_ready", req_ready, 4'b0010);
    chk("haz2_raddr0", raddr0, 5'd7);
    chk("haz2_resp_valid", resp_valid, 4'b0100);
    chk("haz2_resp_data", resp_data, 128'd0);
    tick();
    // rr_ptr=2: req 3 reads, which brings rr_ptr back to 0.
    idle();
    put(3, 1'b0, 5'd3, 32'd0);
    #3;
    chk("haz3_ready", req_ready, 4'b1000);
    chk("haz3_raddr0", raddr0, 5'd3);
    chk("haz3_resp_valid", resp_valid, 4'b0010);
    chk("haz3_resp_data", resp_data, {32'd0, 32'd0, 32'd9, 32'd0});
    tick();

    // Mixed full load (rr_ptr=0).
    idle();
    put(0, 1'b1, 5'd11, 32'h55);
    put(1, 1'b0, 5'd3, 32'd0);
    put(2, 1'b0, 5'd4, 32'd0);
    put(3, 1'b1, 5'd12, 32'h66);
    #3;
    chk("mix_ready", req_ready, 4'b0111);
    chk("mix_waddr", waddr, 5'd11);
    chk("mix_wdata", wdata, 32'h55);
    chk("mix_raddr0", raddr0, 5'd3);
    chk("mix_raddr1", raddr1, 5'd4);
    chk("mix_resp_valid", resp_valid, 4'b1000);
    chk("mix_resp_data", resp_data, {32'hA3, 32'd0, 32'd0, 32'd0});
    chk("mix_conflict", conflict_count, 16'd1);
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b0;
    #3;
    chk("mix2_ready", req_ready, 4'b1000);
    chk("mix2_waddr", waddr, 5'd12);
    chk("mix2_wdata", wdata, 32'h66);
    chk("mix2_resp_valid", resp_valid, 4'b0110);
    chk("mix2_resp_data", resp_data, {32'd0, 32'hA4, 32'hA3, 32'd0});
    tick();

    // Reset mid-operation: two reads granted, then reset on the next cycle.
    idle();
    put(0, 1'b0, 5'd5, 32'd0);
    put(1, 1'b0, 5'd6, 32'd0);
    #3;
    chk("mr_ready", req_ready, 4'b0011);
    tick();
    idle();
    put(2, 1'b0, 5'd7, 32'd0);
    rst = 1'b1;
    #3;
    chk("mr_rst_ready", req_ready, 4'b0000);
    chk("mr_rst_wen", wen, 1'b0);
    chk("mr_rst_raddr0", raddr0, 5'd0);
    chk("mr_rst_resp_valid", resp_valid, 4'b0000);
    tick();
    rst = 1'b0;
    idle();
    put(0, 1'b0, 5'd5, 32'd0);
    put(3, 1'b0, 5'd6, 32'd0);
    #3;
    chk("mr_post_resp_valid", resp_valid, 4'b0000);
    chk("mr_post_conflict", conflict_count, 16'd0);
    chk("mr_post_ready", req_ready, 4'b1001);
    chk("mr_post_raddr0", raddr0, 5'd5);
    chk("mr_post_raddr1", raddr1, 5'd6);
    tick();
    idle();
    #3;
    chk("mr_resp_valid", resp_valid, 4'b1001);
    chk("mr_resp_data", resp_data, {32'hA6, 32'd0, 32'd0, 32'hA5});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
